// File: rtl/vga_capture_pkg.sv
// Shared types and constants for the video capture path: block geometry,
// capture FSM states and the write-buffer entry layout.
package vga_capture_pkg;

  localparam int BLOCK_LEN = 32;

  // Widest coordinate counter supported; the FIFO entry address is sized for it.
  localparam int MAX_WIDTH = 16;

  function automatic int blk_addr_width(input int width);
    return 2 * width - 5;
  endfunction

  localparam int MAX_ADDR_W = blk_addr_width(MAX_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DRAIN
  } cap_state_t;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [BLOCK_LEN-1:0]  data;
    logic [BLOCK_LEN-1:0]  mask;
  } fifo_entry_t;

endpackage

// File: rtl/vga_capture_if.sv
// Cell-RAM write port of the capture block: valid/ready handshake carrying a
// block index, packed cell data and a per-bit write mask.
interface vga_capture_if
  import vga_capture_pkg::*;
#(
  parameter int WIDTH = 12
);

  localparam int ADDR_W = blk_addr_width(WIDTH);

  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_W-1:0]    wr_addr;
  logic [BLOCK_LEN-1:0] wr_data;
  logic [BLOCK_LEN-1:0] wr_mask;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_mask,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_mask,
    output wr_ready
  );

endinterface

// File: rtl/vga_capture_fifo.sv
// Two-entry valid/ready FIFO; the head entry stays stable until it is popped.
module capture_fifo #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] mem [0:1];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  // A simultaneous pop frees the slot, so a full FIFO still accepts then.
  assign out_valid = (count != 2'd0);
  assign in_ready  = (count != 2'd2) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_capture.sv
// Video capture: recovers pixel coordinates from a sync/DE stream, thresholds
// pixels to live/dead cells and writes packed 32-cell blocks to the cell RAM.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int HSIZE     = 800,
  parameter int VSIZE     = 600,
  parameter int HSPP      = 1,
  parameter int VSPP      = 1,
  parameter int P_PARAM_N = 800,
  parameter int P_PARAM_M = 600,
  parameter int THRESHOLD = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic                 data_enable,
  input  logic [7:0]           video_red,
  input  logic [7:0]           video_green,
  input  logic [7:0]           video_blue,
  vga_capture_if.master        wr_if,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int GRID_N = (P_PARAM_N < HSIZE) ? P_PARAM_N : HSIZE;
  localparam int GRID_M = (P_PARAM_M < VSIZE) ? P_PARAM_M : VSIZE;
  localparam int POS_W  = 2 * WIDTH;
  localparam int ADDR_W = blk_addr_width(WIDTH);

  localparam logic [WIDTH-1:0] GRID_N_W = WIDTH'(GRID_N);
  localparam logic [WIDTH-1:0] GRID_M_W = WIDTH'(GRID_M);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(GRID_N * GRID_M - 1);
  localparam logic [9:0]       LIVE_SUM = 10'(3 * THRESHOLD);
  localparam logic             HS_ACT   = 1'(HSPP);
  localparam logic             VS_ACT   = 1'(VSPP);

  logic                 s1_hs, s1_vs, s1_de;
  logic [7:0]           s1_r, s1_g, s1_b;
  logic                 de_prev, vs_prev;
  logic                 vs_edge, de_rise, de_fall;
  logic                 hsync_active_unused;
  logic [WIDTH-1:0]     x_cnt, y_cnt, cur_x;
  logic [9:0]           rgb_sum;
  logic                 s2_pix, s2_in_grid, s2_live;
  logic [POS_W-1:0]     s2_pos;
  cap_state_t           state, state_next;
  logic                 pack, flush, abort, drop, is_last;
  logic [4:0]           bit_idx;
  logic [BLOCK_LEN-1:0] cell_bit, blk_data, blk_mask;
  logic [BLOCK_LEN-1:0] pack_data, pack_mask;
  fifo_entry_t          push_entry, head;
  logic [MAX_ADDR_W-1:0] addr_pad_unused;
  logic                 fifo_in_ready, fifo_out_valid;

  // Stage 1: every video input is registered once; edges come from these copies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_hs   <= ~HS_ACT;
      s1_vs   <= ~VS_ACT;
      s1_de   <= 1'b0;
      s1_r    <= 8'd0;
      s1_g    <= 8'd0;
      s1_b    <= 8'd0;
      de_prev <= 1'b0;
      vs_prev <= ~VS_ACT;
    end else begin
      s1_hs   <= hsync;
      s1_vs   <= vsync;
      s1_de   <= data_enable;
      s1_r    <= video_red;
      s1_g    <= video_green;
      s1_b    <= video_blue;
      de_prev <= s1_de;
      vs_prev <= s1_vs;
    end
  end

  assign vs_edge = (s1_vs == VS_ACT) && (vs_prev != VS_ACT);
  assign de_rise = s1_de && !de_prev;
  assign de_fall = !s1_de && de_prev;
  // Line timing is taken from data_enable; hsync is only carried for alignment.
  assign hsync_active_unused = (s1_hs == HS_ACT);

  assign cur_x = de_rise ? '0 : x_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (s1_de) begin
        x_cnt <= cur_x + 1'b1;
      end
      if (vs_edge) begin
        y_cnt <= '0;
      end else if (de_fall) begin
        y_cnt <= y_cnt + 1'b1;
      end
    end
  end

  assign rgb_sum = {2'b00, s1_r} + {2'b00, s1_g} + {2'b00, s1_b};

  // Stage 2: linear cell position, grid membership and the live decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_pix     <= 1'b0;
      s2_in_grid <= 1'b0;
      s2_live    <= 1'b0;
      s2_pos     <= '0;
    end else begin
      s2_pix     <= s1_de;
      s2_in_grid <= (cur_x < GRID_N_W) && (y_cnt < GRID_M_W);
      s2_live    <= (rgb_sum >= LIVE_SUM);
      s2_pos     <= POS_W'(y_cnt) * POS_W'(GRID_N) + POS_W'(cur_x);
    end
  end

  assign bit_idx  = s2_pos[4:0];
  assign cell_bit = {{(BLOCK_LEN-1){1'b0}}, 1'b1} << bit_idx;
  assign is_last  = (s2_pos == LAST_POS);
  assign abort    = (state == CAPTURE) && vs_edge;
  assign pack     = (state == CAPTURE) && s2_pix && s2_in_grid && !vs_edge;
  assign flush    = pack && ((bit_idx == 5'd31) || is_last);
  assign blk_data = pack_data | (s2_live ? cell_bit : '0);
  assign blk_mask = pack_mask | cell_bit;
  assign drop     = flush && !fifo_in_ready;

  assign push_entry = '{addr: MAX_ADDR_W'(s2_pos[POS_W-1:5]),
                        data: blk_data,
                        mask: blk_mask};

  // The packer always restarts empty after a flush, an abort or outside CAPTURE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack_data <= '0;
      pack_mask <= '0;
    end else if ((state != CAPTURE) || vs_edge || flush) begin
      pack_data <= '0;
      pack_mask <= '0;
    end else if (pack) begin
      pack_data <= blk_data;
      pack_mask <= blk_mask;
    end
  end

  capture_fifo #(
    .DW($bits(fifo_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (flush),
    .in_ready  (fifo_in_ready),
    .in_data   (push_entry),
    .out_valid (fifo_out_valid),
    .out_ready (wr_if.wr_ready),
    .out_data  (head)
  );

  // Entry address is sized for the widest configuration; upper bits stay zero.
  assign addr_pad_unused = head.addr;
  assign wr_if.wr_valid  = fifo_out_valid;
  assign wr_if.wr_addr   = head.addr[ADDR_W-1:0];
  assign wr_if.wr_data   = head.data;
  assign wr_if.wr_mask   = head.mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (arm) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (vs_edge) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (vs_edge) begin
          state_next = IDLE;
        end else if (pack && is_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!fifo_out_valid && (pack_mask == '0)) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sticky until the next accepted arm; set by a dropped block or a short frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if ((state == IDLE) && arm) begin
      overflow <= 1'b0;
    end else if (drop || abort) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a 64x4 frame, plus a 40-column grid instance.
`timescale 1ns/1ps
module tb_vga_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       arm, arm40;
  logic       hsync, vsync, data_enable;
  logic [7:0] red, green, blue;
  logic       busy, frame_done, overflow;
  logic       busy40, frame_done40, overflow40;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done40_cnt = 0;
  int hold_err = 0;
  int first_valid_cyc = -1;
  int pix31_cyc = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] held_addr, held_data, held_mask;
  logic [31:0] wq_addr[$], wq_data[$], wq_mask[$];
  logic [31:0] w40_addr[$], w40_data[$], w40_mask[$];

  always #5 clk = ~clk;

  vga_capture_if #(.WIDTH(12)) bus ();
  vga_capture_if #(.WIDTH(12)) bus40 ();

  vga_capture #(
    .WIDTH(12), .HSIZE(64), .VSIZE(4), .HSPP(1), .VSPP(1),
    .P_PARAM_N(64), .P_PARAM_M(4), .THRESHOLD(128)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .hsync(hsync), .vsync(vsync),
    .data_enable(data_enable), .video_red(red), .video_green(green),
    .video_blue(blue), .wr_if(bus), .busy(busy), .frame_done(frame_done),
    .overflow(overflow)
  );

  vga_capture #(
    .WIDTH(12), .HSIZE(64), .VSIZE(4), .HSPP(1), .VSPP(1),
    .P_PARAM_N(40), .P_PARAM_M(4), .THRESHOLD(128)
  ) dut40 (
    .clk(clk), .reset(reset), .arm(arm40), .hsync(hsync), .vsync(vsync),
    .data_enable(data_enable), .video_red(red), .video_green(green),
    .video_blue(blue), .wr_if(bus40), .busy(busy40), .frame_done(frame_done40),
    .overflow(overflow40)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the write ports half a cycle away from the active edge.
  always @(negedge clk) begin
    if (bus.wr_valid && bus.wr_ready) begin
      wq_addr.push_back(32'(bus.wr_addr));
      wq_data.push_back(bus.wr_data);
      wq_mask.push_back(bus.wr_mask);
    end
    if (bus40.wr_valid && bus40.wr_ready) begin
      w40_addr.push_back(32'(bus40.wr_addr));
      w40_data.push_back(bus40.wr_data);
      w40_mask.push_back(bus40.wr_mask);
    end
    if (frame_done) done_cnt++;
    if (frame_done40) done40_cnt++;
    if (hold_prev && bus.wr_valid &&
        (32'(bus.wr_addr) != held_addr || bus.wr_data != held_data || bus.wr_mask != held_mask))
      hold_err++;
    hold_prev = bus.wr_valid && !bus.wr_ready;
    held_addr = 32'(bus.wr_addr);
    held_data = bus.wr_data;
    held_mask = bus.wr_mask;
    if (bus.wr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic h, input logic v, input logic de, input logic [23:0] rgb);
    hsync       = h;
    vsync       = v;
    data_enable = de;
    {red, green, blue} = rgb;
    tick();
  endtask

  function automatic logic [23:0] pix(input int mode, input int x, input int y);
    case (mode)
      0:       return (((x + y) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      1:       return {8'd200, 8'd200, 8'd200};
      2: begin
        if (y == 0 && x == 0) return {8'd127, 8'd128, 8'd129};
        if (y == 0 && x == 1) return {8'd127, 8'd128, 8'd128};
        return 24'h000000;
      end
      default: return ((x % 2) == 0 || x >= 40) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic send_frame(input int mode, input int lines);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < 64; x++) begin
        if (x == 31 && y == 0) pix31_cyc = cyc;
        applyStimulus(1'b0, 1'b0, 1'b1, pix(mode, x, y));
      end
      repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 24'h0);
      repeat (12) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    end
  endtask

  task automatic wait_idle(input bit sel, input int budget, input string tag);
    int n = 0;
    while ((sel ? busy40 : busy) && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(sel ? busy40 : busy), 64'(0));
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic clear_queues();
    wq_addr.delete(); wq_data.delete(); wq_mask.delete();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int n0;
    reset = 1'b1;
    arm = 1'b0; arm40 = 1'b0;
    hsync = 1'b0; vsync = 1'b0; data_enable = 1'b0;
    red = 8'd0; green = 8'd0; blue = 8'd0;
    bus.wr_ready = 1'b0;
    bus40.wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_wr_valid", 64'(bus.wr_valid), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_frame_done", 64'(frame_done), 64'(0));
    checkOutput("rst_overflow", 64'(overflow), 64'(0));
    reset = 1'b0;
    repeat (3) tick();

    $display("[TB] checkerboard frame, wr_ready=1");
    clear_queues();
    bus.wr_ready = 1'b1;
    first_valid_cyc = -1;
    pulse_arm();
    checkOutput("cb_armed_busy", 64'(busy), 64'(1));
    send_frame(0, 4);
    wait_idle(1'b0, 200, "cb_idle");
    checkOutput("cb_write_count", 64'(wq_addr.size()), 64'(8));
    for (int i = 0; i < wq_addr.size() && i < 8; i++) begin
      checkOutput($sformatf("cb_addr%0d", i), 64'(wq_addr[i]), 64'(i));
      checkOutput($sformatf("cb_data%0d", i), 64'(wq_data[i]),
                  ((i / 2) % 2 == 0) ? 64'h00000000AAAAAAAA : 64'h0000000055555555);
      checkOutput($sformatf("cb_mask%0d", i), 64'(wq_mask[i]), 64'hFFFFFFFF);
    end
    checkOutput("cb_frame_done", 64'(done_cnt), 64'(1));
    checkOutput("cb_latency", 64'(first_valid_cyc - pix31_cyc), 64'(3));
    checkOutput("cb_overflow", 64'(overflow), 64'(0));

    $display("[TB] all-live frame with wr_ready held low");
    clear_queues();
    d0 = done_cnt;
    hold_err = 0;
    bus.wr_ready = 1'b0;
    pulse_arm();
    send_frame(1, 4);
    repeat (10) tick();
    checkOutput("ovf_valid", 64'(bus.wr_valid), 64'(1));
    checkOutput("ovf_head_addr", 64'(bus.wr_addr), 64'(0));
    checkOutput("ovf_head_data", 64'(bus.wr_data), 64'hFFFFFFFF);
    checkOutput("ovf_flag", 64'(overflow), 64'(1));
    checkOutput("ovf_still_busy", 64'(busy), 64'(1));
    checkOutput("ovf_no_accept", 64'(wq_addr.size()), 64'(0));
    bus.wr_ready = 1'b1;
    wait_idle(1'b0, 50, "ovf_idle");
    checkOutput("ovf_write_count", 64'(wq_addr.size()), 64'(2));
    for (int i = 0; i < wq_addr.size() && i < 2; i++) begin
      checkOutput($sformatf("ovf_addr%0d", i), 64'(wq_addr[i]), 64'(i));
      checkOutput($sformatf("ovf_data%0d", i), 64'(wq_data[i]), 64'hFFFFFFFF);
    end
    checkOutput("ovf_hold_stable", 64'(hold_err), 64'(0));
    checkOutput("ovf_frame_done", 64'(done_cnt - d0), 64'(1));
    checkOutput("ovf_sticky", 64'(overflow), 64'(1));

    $display("[TB] threshold boundary frame");
    clear_queues();
    pulse_arm();
    checkOutput("thr_arm_clears_ovf", 64'(overflow), 64'(0));
    send_frame(2, 4);
    wait_idle(1'b0, 200, "thr_idle");
    checkOutput("thr_write_count", 64'(wq_addr.size()), 64'(8));
    if (wq_data.size() >= 2) begin
      checkOutput("thr_blk0_data", 64'(wq_data[0]), 64'h1);
      checkOutput("thr_blk0_mask", 64'(wq_mask[0]), 64'hFFFFFFFF);
      checkOutput("thr_blk1_data", 64'(wq_data[1]), 64'h0);
    end

    $display("[TB] 40-column grid");
    d0 = done40_cnt;
    arm40 = 1'b1;
    tick();
    arm40 = 1'b0;
    send_frame(3, 4);
    wait_idle(1'b1, 200, "n40_idle");
    checkOutput("n40_write_count", 64'(w40_addr.size()), 64'(5));
    for (int i = 0; i < w40_addr.size() && i < 5; i++) begin
      checkOutput($sformatf("n40_addr%0d", i), 64'(w40_addr[i]), 64'(i));
      checkOutput($sformatf("n40_data%0d", i), 64'(w40_data[i]), 64'h55555555);
      checkOutput($sformatf("n40_mask%0d", i), 64'(w40_mask[i]), 64'hFFFFFFFF);
    end
    checkOutput("n40_frame_done", 64'(done40_cnt - d0), 64'(1));
    checkOutput("n40_overflow", 64'(overflow40), 64'(0));

    $display("[TB] short frame");
    clear_queues();
    d0 = done_cnt;
    pulse_arm();
    send_frame(0, 2);
    checkOutput("short_busy_before", 64'(busy), 64'(1));
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
    checkOutput("short_busy_after", 64'(busy), 64'(0));
    checkOutput("short_overflow", 64'(overflow), 64'(1));
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("short_no_done", 64'(done_cnt - d0), 64'(0));
    checkOutput("short_write_count", 64'(wq_addr.size()), 64'(4));
    pulse_arm();
    checkOutput("short_rearm_clears", 64'(overflow), 64'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] reset during a stalled write");
    clear_queues();
    bus.wr_ready = 1'b0;
    pulse_arm();
    send_frame(1, 4);
    repeat (5) tick();
    checkOutput("rstw_valid_before", 64'(bus.wr_valid), 64'(1));
    reset = 1'b1;
    #1;
    checkOutput("rstw_valid_drop", 64'(bus.wr_valid), 64'(0));
    tick();
    tick();
    reset = 1'b0;
    bus.wr_ready = 1'b1;
    n0 = wq_addr.size();
    repeat (20) tick();
    checkOutput("rstw_busy", 64'(busy), 64'(0));
    checkOutput("rstw_no_stale", 64'(wq_addr.size() - n0), 64'(0));
    checkOutput("rstw_overflow", 64'(overflow), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
